// File: rtl/pixel_stream_pkg.sv
// Shared types and default raster geometry for the pixel stream scanner.
// Optional frame counter is enabled by defining PIXEL_SCANNER_FRAME_COUNT_EN.
package pixel_stream_pkg;

    localparam int DEFAULT_WIDTH  = 640;
    localparam int DEFAULT_HEIGHT = 480;
    localparam int DEFAULT_DATA_W = 12;

    typedef enum logic [1:0] {
        SEEK,
        ACTIVE,
        WAIT_SOP
    } scan_state_t;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] data;
        logic                      sop;
        logic                      eop;
    } pix_entry_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with show-ahead read, full/empty flags and an occupancy count.
// A push is refused while full, even if a pop happens in the same cycle.
module pixel_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic          doPush;
    logic          doPop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= wdata_i;
    end

endmodule

// File: rtl/pixel_stream_scanner.sv
// Buffers a SOP/EOP-framed pixel stream and re-emits it as raster-coordinate strobes,
// resynchronising on frame boundaries. Define PIXEL_SCANNER_FRAME_COUNT_EN to build frame_count.
module pixel_stream_scanner
    import pixel_stream_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int HEIGHT     = DEFAULT_HEIGHT,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              vga_ready,
    output logic [DATA_W-1:0] filtered_video,
    output logic [9:0]        x_count,
    output logic [8:0]        y_count,
    output logic              frame_done,
    output logic              sync_error,
    output logic [15:0]       frame_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [9:0]    X_LAST     = 10'(WIDTH - 1);
    localparam logic [8:0]    Y_LAST     = 9'(HEIGHT - 1);

    scan_state_t       state_q;
    logic [9:0]        xNext_q, xNext_d, entryX;
    logic [8:0]        yNext_q, yNext_d, entryY;
    logic              fifoFull, fifoEmpty, popEn;
    logic [CW-1:0]     fifoCount;
    logic [DATA_W+1:0] fifoRdata;
    logic [DATA_W-1:0] popData;
    logic              popSop, popEop;
    logic              atLast, restartErr, endErr, dropEntry;

    logic              s1Valid_q, s1Done_q, s1Err_q;
    logic [DATA_W-1:0] s1Data_q;
    logic [9:0]        s1X_q;
    logic [8:0]        s1Y_q;

    logic              vgaReady_q, frameDone_q, syncError_q;
    logic [DATA_W-1:0] pixel_q;
    logic [9:0]        xCount_q;
    logic [8:0]        yCount_q;

    assign in_ready = (fifoCount != FULL_COUNT);
    assign popEn    = !fifoEmpty && ((state_q == SEEK) || out_ready);

    pixel_fifo #(
        .W     (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid && !fifoFull),
        .wdata_i ({in_data, in_sop, in_eop}),
        .pop_i   (popEn),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    assign popData = fifoRdata[DATA_W+1:2];
    assign popSop  = fifoRdata[1];
    assign popEop  = fifoRdata[0];

    // An SOP always lands at the origin; EOP checks are then applied at that position.
    assign entryX     = popSop ? '0 : xNext_q;
    assign entryY     = popSop ? '0 : yNext_q;
    assign atLast     = (entryX == X_LAST) && (entryY == Y_LAST);
    assign restartErr = popSop && (state_q == ACTIVE) && ((xNext_q != '0) || (yNext_q != '0));
    assign endErr     = (popEop != atLast);
    assign dropEntry  = !popSop && (state_q != ACTIVE);
    assign xNext_d    = (entryX == X_LAST) ? '0 : entryX + 10'd1;
    assign yNext_d    = (entryX == X_LAST) ? entryY + 9'd1 : entryY;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SEEK;
            xNext_q   <= '0;
            yNext_q   <= '0;
            s1Valid_q <= 1'b0;
            s1Done_q  <= 1'b0;
            s1Err_q   <= 1'b0;
            s1Data_q  <= '0;
            s1X_q     <= '0;
            s1Y_q     <= '0;
        end else begin
            s1Valid_q <= 1'b0;
            s1Done_q  <= 1'b0;
            s1Err_q   <= 1'b0;
            if (popEn) begin
                if (dropEntry) begin
                    s1Err_q <= (state_q == WAIT_SOP);
                    state_q <= SEEK;
                end else begin
                    s1Valid_q <= 1'b1;
                    s1Data_q  <= popData;
                    s1X_q     <= entryX;
                    s1Y_q     <= entryY;
                    s1Err_q   <= restartErr || endErr;
                    s1Done_q  <= atLast && popEop;
                    if (atLast && popEop) begin
                        state_q <= WAIT_SOP;
                    end else if (endErr) begin
                        state_q <= SEEK;
                    end else begin
                        state_q <= ACTIVE;
                        xNext_q <= xNext_d;
                        yNext_q <= yNext_d;
                    end
                end
            end
        end
    end

    // Output stage: pixel fields only load on a strobe so they hold between pixels.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vgaReady_q  <= 1'b0;
            frameDone_q <= 1'b0;
            syncError_q <= 1'b0;
            pixel_q     <= '0;
            xCount_q    <= '0;
            yCount_q    <= '0;
        end else begin
            vgaReady_q  <= s1Valid_q;
            frameDone_q <= s1Done_q;
            syncError_q <= s1Err_q;
            if (s1Valid_q) begin
                pixel_q  <= s1Data_q;
                xCount_q <= s1X_q;
                yCount_q <= s1Y_q;
            end
        end
    end

    assign vga_ready      = vgaReady_q;
    assign frame_done     = frameDone_q;
    assign sync_error     = syncError_q;
    assign filtered_video = pixel_q;
    assign x_count        = xCount_q;
    assign y_count        = yCount_q;

`ifdef PIXEL_SCANNER_FRAME_COUNT_EN
    logic [15:0] frameCount_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frameCount_q <= '0;
        end else if (s1Done_q) begin
            frameCount_q <= frameCount_q + 16'd1;
        end
    end

    assign frame_count = frameCount_q;
`else
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_pixel_stream_scanner.sv
// Directed bench for pixel_stream_scanner on a 4x2 raster with a 4-entry FIFO.
// Expected strobe lists are written out per scenario and compared event by event.
module tb_pixel_stream_scanner;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DW    = 12;
    localparam int DEPTH = 4;
`ifdef PIXEL_SCANNER_FRAME_COUNT_EN
    localparam int FC_EN = 1;
`else
    localparam int FC_EN = 0;
`endif

    typedef logic [33:0] ev_t;

    logic          clk;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_sop;
    logic          in_eop;
    logic          in_ready;
    logic          out_ready;
    logic          vga_ready;
    logic [DW-1:0] filtered_video;
    logic [9:0]    x_count;
    logic [8:0]    y_count;
    logic          frame_done;
    logic          sync_error;
    logic [15:0]   frame_count;

    ev_t gotQ[$];
    ev_t expQ[$];
    int  stampQ[$];
    int  vecCount = 0;
    int  missCount = 0;
    int  cyc = 0;
    int  acceptCyc = 0;
    int  frameStartCyc = 0;
    int  acceptCount = 0;
    bit  countAccepts = 0;
    bit  found;

    pixel_stream_scanner #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_sop         (in_sop),
        .in_eop         (in_eop),
        .in_ready       (in_ready),
        .out_ready      (out_ready),
        .vga_ready      (vga_ready),
        .filtered_video (filtered_video),
        .x_count        (x_count),
        .y_count        (y_count),
        .frame_done     (frame_done),
        .sync_error     (sync_error),
        .frame_count    (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!countAccepts) acceptCount = 0;
        else if (in_valid && in_ready) acceptCount = acceptCount + 1;
    end

    // Record every cycle that carries a strobe or a flag; pixel fields are masked on drops.
    always @(negedge clk) begin
        if (reset && (vga_ready || sync_error || frame_done)) begin
            if (vga_ready) gotQ.push_back({1'b1, sync_error, frame_done, x_count, y_count, filtered_video});
            else           gotQ.push_back({1'b0, sync_error, frame_done, 31'd0});
            stampQ.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input logic s, input logic e);
        bit acc;
        int waitCyc;
        @(negedge clk);
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_valid = 1'b1;
        waitCyc  = 0;
        acc      = in_ready;
        @(posedge clk);
        while (!acc && waitCyc < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            waitCyc++;
        end
        if (!acc) checkOutput("acceptTimeout", 64'd0, 64'd1);
        #1 acceptCyc = cyc;
    endtask

    task automatic idleDrive(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sop   = 1'b0;
            in_eop   = 1'b0;
        end
    endtask

    task automatic sendFrame(input int base);
        for (int i = 0; i < W * H; i++) begin
            applyStimulus(DW'(base + i), i == 0, i == W * H - 1);
            if (i == 0) frameStartCyc = acceptCyc;
        end
    endtask

    function automatic void expPix(input int d, input int x, input int y, input bit done, input bit err);
        expQ.push_back({1'b1, err, done, 10'(x), 9'(y), DW'(d)});
    endfunction

    function automatic void expFrame(input int base);
        for (int i = 0; i < W * H; i++) expPix(base + i, i % W, i / W, i == W * H - 1, 1'b0);
    endfunction

    task automatic runChecks(input string tag);
        int n;
        checkOutput({tag, ".events"}, 64'(gotQ.size()), 64'(expQ.size()));
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        for (int i = 0; i < n; i++) checkOutput($sformatf("%s.ev%0d", tag, i), 64'(gotQ[i]), 64'(expQ[i]));
        gotQ.delete();
        expQ.delete();
        stampQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".vga_ready"}, 64'(vga_ready), 64'd0);
        checkOutput({tag, ".x_count"}, 64'(x_count), 64'd0);
        checkOutput({tag, ".y_count"}, 64'(y_count), 64'd0);
        checkOutput({tag, ".video"}, 64'(filtered_video), 64'd0);
        checkOutput({tag, ".frame_done"}, 64'(frame_done), 64'd0);
        checkOutput({tag, ".sync_error"}, 64'(sync_error), 64'd0);
        checkOutput({tag, ".frame_count"}, 64'(frame_count), 64'd0);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1 checkAllZero("rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst.in_ready", 64'(in_ready), 64'd1);

        // Junk before the first SOP is dropped silently, then a clean frame.
        for (int i = 0; i < 3; i++) applyStimulus(DW'(12'h0F1 + i), 1'b0, 1'b0);
        idleDrive(4);
        sendFrame(12'h100);
        idleDrive(6);
        checkOutput("latency", 64'((stampQ.size() > 0) ? stampQ[0] - frameStartCyc : -1), 64'd2);
        expFrame(12'h100);
        runChecks("seek");
        checkOutput("fc1", 64'(frame_count), 64'(FC_EN));

        // Non-SOP right after a complete frame raises an error and is dropped.
        applyStimulus(12'h0E0, 1'b0, 1'b0);
        idleDrive(4);
        expQ.push_back({1'b0, 1'b1, 1'b0, 31'd0});
        sendFrame(12'h200);
        idleDrive(6);
        expFrame(12'h200);
        runChecks("waitsop");

        // SOP as the 5th pixel restarts the frame at the origin.
        for (int i = 0; i < 12; i++) applyStimulus(DW'(12'h300 + i), (i == 0) || (i == 4), i == 11);
        idleDrive(6);
        for (int i = 0; i < 4; i++) expPix(12'h300 + i, i, 0, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) expPix(12'h304 + j, j % W, j / W, j == 7, j == 0);
        runChecks("midsop");

        // Early EOP: error on (2,0), then silent drop until the next SOP.
        applyStimulus(12'h400, 1'b1, 1'b0);
        applyStimulus(12'h401, 1'b0, 1'b0);
        applyStimulus(12'h402, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(DW'(12'h4F0 + i), 1'b0, 1'b0);
        idleDrive(4);
        sendFrame(12'h500);
        idleDrive(6);
        expPix(12'h400, 0, 0, 1'b0, 1'b0);
        expPix(12'h401, 1, 0, 1'b0, 1'b0);
        expPix(12'h402, 2, 0, 1'b0, 1'b1);
        expFrame(12'h500);
        runChecks("earlyeop");

        // Downstream stall mid-frame: FIFO fills after four accepts, nothing lost.
        for (int i = 0; i < 3; i++) applyStimulus(DW'(12'h600 + i), i == 0, 1'b0);
        idleDrive(4);
        @(negedge clk);
        out_ready    = 1'b0;
        countAccepts = 1'b1;
        fork
            begin
                for (int i = 3; i < 8; i++) applyStimulus(DW'(12'h600 + i), 1'b0, i == 7);
                idleDrive(1);
            end
            begin
                repeat (10) @(negedge clk);
                checkOutput("stall.in_ready", 64'(in_ready), 64'd0);
                checkOutput("stall.accepts", 64'(acceptCount), 64'd4);
                countAccepts = 1'b0;
                out_ready    = 1'b1;
            end
        join
        idleDrive(8);
        expFrame(12'h600);
        runChecks("stall");
        checkOutput("fc5", 64'(frame_count), 64'(5 * FC_EN));

        // Reset in the middle of a frame at pixel (2,1).
        for (int i = 0; i < 7; i++) applyStimulus(DW'(12'h700 + i), i == 0, 1'b0);
        idleDrive(1);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            found = vga_ready && (x_count == 10'd2) && (y_count == 9'd1);
        end
        checkOutput("rst2.found", 64'(found), 64'd1);
        #1 reset = 1'b0;
        #1 checkAllZero("rst2");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst2.in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 7; i++) expPix(12'h700 + i, i % W, i / W, 1'b0, 1'b0);
        sendFrame(12'h800);
        idleDrive(6);
        expFrame(12'h800);
        runChecks("reset");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/pixel_stream_scanner.md
# pixel_stream_scanner

Source end of the raster pixel interface consumed by the edge-density and other per-pixel analysis blocks. Accepts a packetised valid/ready video stream (start/end-of-frame flags), buffers it in a small FIFO, and re-emits each pixel as a one-cycle `vga_ready` strobe with its `x_count`/`y_count` raster coordinates. It resynchronises to frame boundaries and flags malformed frames, so downstream counters never see a misaligned (0,0) or a truncated frame.

## Interface
- `WIDTH`, 640, active pixels per line
- `HEIGHT`, 480, active lines per frame
- `DATA_W`, 12, pixel width
- `FIFO_DEPTH`, 4, buffer entries (power of two, ≥2)
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-low reset
- `in_data`  in  DATA_W  upstream pixel
- `in_valid`  in  1  upstream pixel valid
- `in_sop`  in  1  pixel is first of frame
- `in_eop`  in  1  pixel is last of frame
- `in_ready`  out  1  accept; transfer when `in_valid && in_ready`
- `out_ready`  in  1  downstream may take a pixel this cycle
- `vga_ready`  out  1  one-cycle strobe: outputs below carry a pixel
- `filtered_video`  out  DATA_W  emitted pixel
- `x_count`  out  10  column of emitted pixel
- `y_count`  out  9  line of emitted pixel
- `frame_done`  out  1  pulse with last pixel of a well-formed frame
- `sync_error`  out  1  pulse on any framing violation
- `frame_count`  out  16  completed well-formed frames (see Configuration)

## Operation
- FIFO stores {data, sop, eop}. `in_ready = !full`. No push when full, even if a pop occurs that cycle.
- Pop condition: FIFO non-empty and (state SEEK, or `out_ready`).
- States: SEEK (drop until SOP), ACTIVE (mid-frame), WAIT_SOP (frame complete, next entry must be SOP).
- SEEK: pop and discard non-SOP entries with no strobe. On an SOP entry, emit it at (0,0) and go to ACTIVE.
- ACTIVE: emit each popped entry at the next raster position. x increments and wraps at WIDTH-1 to 0 with y+1.
  - SOP entry not at (0,0) → `sync_error`; emit it at (0,0) and restart the frame.
  - EOP entry before (WIDTH-1, HEIGHT-1) → `sync_error`; emit it, then go to SEEK.
  - Entry at (WIDTH-1, HEIGHT-1) with EOP → `frame_done`; go to WAIT_SOP.
  - Entry at (WIDTH-1, HEIGHT-1) without EOP → `sync_error`; emit it, then go to SEEK.
  - An SOP+EOP entry counts as SOP first (restart), then EOP checks apply at (0,0).
- WAIT_SOP: an SOP entry is emitted at (0,0) and the block goes to ACTIVE. A non-SOP entry raises `sync_error`, is dropped, and the block goes to SEEK.
- `x_count`/`y_count`/`filtered_video` hold their last value while `vga_ready` is 0.

## Timing
- All outputs registered except `in_ready`, which is combinational from the FIFO count.
- Latency: a pixel accepted on edge k appears with `vga_ready`=1 after edge k+2, given an empty FIFO and `out_ready`=1.
- Throughput: 1 pixel/cycle sustained with `out_ready` held high.
- `frame_done` and `sync_error` are coincident with the relevant pixel's strobe (or with the drop cycle for a WAIT_SOP error). Each is one cycle wide.
- Reset (any time, including mid-frame) clears immediately:
  - FIFO emptied; state → SEEK.
  - `vga_ready`, `frame_done`, `sync_error` → 0.
  - `x_count`, `y_count`, `filtered_video`, `frame_count` → 0.
  - `in_ready` → 1 once reset is released.
- `frame_count` wraps from 0xFFFF to 0.

## Configuration
- `PIXEL_SCANNER_FRAME_COUNT_EN`
  - Defined: `frame_count` increments on each `frame_done`.
  - Undefined: the counter is not built and `frame_count` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `pixel_stream_pkg`:
  - state enum `scan_state_t` {SEEK, ACTIVE, WAIT_SOP}
  - FIFO entry struct `pix_entry_t` {data, sop, eop}
  - default WIDTH/HEIGHT constants
- One sub-module `pixel_fifo`: synchronous FIFO with full/empty flags and a count, parameterised by DATA_W+2 and FIFO_DEPTH.

## Test plan
- Common setup: WIDTH=4, HEIGHT=2; one well-formed 8-pixel frame (SOP on pixel 0, EOP on pixel 7), `out_ready`=1.
  - → 8 strobes at (0,0)…(3,1) in order.
  - → `frame_done` on the (3,1) strobe only; `frame_count`=1 with the macro, 0 without.
- Three non-SOP pixels, then a good frame → first three dropped with no strobe and no error; the frame is emitted from (0,0).
- SOP injected as the 5th pixel of a frame → `sync_error` on that strobe; it is emitted at (0,0) and the following 7 pixels complete normally with `frame_done`.
- EOP on the 3rd pixel → `sync_error` on strobe (2,0); later non-SOP pixels are dropped until the next SOP.
- `out_ready` low for 10 cycles mid-frame:
  - `in_ready` falls after 4 accepts.
  - No pixel is lost or duplicated, and coordinates continue contiguously once `out_ready` returns.
- `reset` asserted at pixel (2,1) → all outputs 0 immediately; the next frame starts at (0,0) with no spurious `sync_error`.
